aes_host_ctrl: RTL and testbench
================================

Name: aes_host_ctrl

Overview:
- Initiator-side sequencer for the AES_ENC / AES_DEC core pair.
- Accepts one-block requests (mode, optional new key, data) on a valid/ready interface and drives the shared core handshake: EN select, Key/Krdy pulse, Din/Drdy pulse.
- Waits for Dvld from the selected engine, then returns Dout on a valid/ready response port.
- Sits between the bus/register front end and the two AES cores; caches key-loaded state per engine so that repeat blocks skip the key phase.

Parameters:
- TIMEOUT, 32, max cycles in WAIT for Dvld before an error response (range 16..255).
- CW, 8, width of the timeout counter.

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_mode  in  1  0 = encrypt (ENC engine), 1 = decrypt (DEC engine)
- req_knew  in  1  force key load for this request
- req_key  in  128  key (for decrypt: final encryption round key)
- req_data  in  128  plaintext or ciphertext
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  128  result block
- rsp_err  out  1  timeout occurred
- Key  out  128  to both cores
- Krdy  out  1  key strobe, shared
- Din  out  128  to both cores
- Drdy  out  1  data strobe, shared
- EN_E  out  1  ENC enable
- EN_D  out  1  DEC enable
- BSY_E, BSY_D  in  1 each  core busy
- Dvld_E, Dvld_D  in  1 each  core output valid
- Dout_E, Dout_D  in  128 each  core outputs

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; key-cache flags kv_e and kv_d = 0; timeout counter 0.
- All core-side outputs are registered.
- States: IDLE, KEY, DATA, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch mode, key and data. Set EN of the selected engine to 1 and the other to 0.
  - Next state is KEY if req_knew = 1, or if the selected cache flag is 0, or if the latched key differs from the cached key of that engine. Otherwise DATA.
- KEY: drive Key, assert Krdy for exactly one cycle, set the selected cache flag, store the key in that engine's cache register, go to DATA.
- DATA:
  - If the selected BSY is 1, hold with Drdy = 0.
  - Otherwise drive Din, assert Drdy for exactly one cycle, clear the counter, go to WAIT.
  - Krdy and Drdy are never high in the same cycle.
- WAIT:
  - Increment the counter each cycle.
  - On the selected Dvld: capture the selected Dout into rsp_data, rsp_err = 0, go to RESP.
  - Dvld from the non-selected engine is ignored.
  - If the counter reaches TIMEOUT first: rsp_data = 0, rsp_err = 1, clear the selected cache flag, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - req_ready is 0 throughout, so a new request can be accepted no earlier than the cycle after the response handshake.
- EN persistence:
  - EN of the last-used engine stays 1 in IDLE.
  - A mode change switches EN at acceptance. The cores retain their loaded key across EN deassertion.
- Latency from request acceptance to rsp_valid (core Dvld at N cycles after Drdy): N+2 cycles with key load, N+1 cycles without.
- Reset mid-operation: immediate return to reset values. Any pending Krdy/Drdy pulse is cut, both cache flags are cleared, and no response is issued.

Decomposition:
- Shared package aes_pkg: state encoding, MODE_ENC/MODE_DEC constants, 128-bit block typedef, FIPS-197 test-vector constants.
- No sub-module. The key cache (two 128-bit registers plus flags) stays inline.

Test Plan:
- Encrypt, new key: req_mode = 0, req_knew = 1, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> one Krdy pulse, then one Drdy pulse, EN_E = 1; rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err = 0.
- Decrypt: req_mode = 1, key 13111d7fe3944a17f307a78b4d2b30c5, data 69c4e0d8...c55a -> EN_D = 1, EN_E = 0; rsp_data = 00112233...eeff.
- Repeat encrypt with the same key, req_knew = 0 -> no Krdy pulse; latency one cycle shorter than the first encrypt; same ciphertext.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready = 0 throughout.
- Timeout: stub core never asserts Dvld -> rsp_err = 1, rsp_data = 0 after TIMEOUT cycles in WAIT; the next same-key request performs a key load.
- Reset asserted in WAIT -> all outputs 0 immediately; after release, an encrypt with req_knew = 0 still loads the key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES host sequencer: FSM encoding, engine
// select values, the 128-bit block type and the FIPS-197 reference vectors.
package aes_pkg;

    typedef logic [127:0] blk_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KEY  = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // FIPS-197 appendix C.1; DKEY is the final round key that the DEC core expects.
    localparam blk_t FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam blk_t FIPS_DKEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam blk_t FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam blk_t FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_host_ctrl.sv
// Initiator-side sequencer for the AES_ENC / AES_DEC pair: accepts one-block
// requests, loads keys only when the per-engine cache misses, returns Dout.
module aes_host_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CW      = 8
) (
    input  logic         CLK,
    input  logic         RSTn,
    // Request: accepted on a cycle where req_valid and req_ready are both high.
    // Response: held stable from rsp_valid until the cycle rsp_ready is seen.
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic         req_knew,
    input  logic [127:0] req_key,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic [127:0] Key,
    output logic         Krdy,
    output logic [127:0] Din,
    output logic         Drdy,
    output logic         EN_E,
    output logic         EN_D,
    input  logic         BSY_E,
    input  logic         BSY_D,
    input  logic         Dvld_E,
    input  logic         Dvld_D,
    input  logic [127:0] Dout_E,
    input  logic [127:0] Dout_D,
    output logic [2:0]   dbg_state
);

    state_t          r_state;
    state_t          w_next;
    logic            r_mode;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [127:0]    r_rsp_data;
    logic            r_rsp_err;
    logic [127:0]    r_key;
    logic            r_krdy;
    logic [127:0]    r_din;
    logic            r_drdy;
    logic            r_en_e;
    logic            r_en_d;
    logic            r_kv_e;
    logic            r_kv_d;
    blk_t            r_kc_e;
    blk_t            r_kc_d;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_need_key;
    logic            w_mode;
    logic            w_bsy;
    logic            w_dvld;
    logic            w_timeout;

    assign w_accept   = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_need_key = req_knew
                      || !(req_mode ? r_kv_d : r_kv_e)
                      || (req_key != (req_mode ? r_kc_d : r_kc_e));
    // BSY is examined on the edge that enters DATA, when the mode is not yet latched.
    assign w_mode     = (r_state == S_IDLE) ? req_mode : r_mode;
    assign w_bsy      = w_mode ? BSY_D : BSY_E;
    assign w_dvld     = r_mode ? Dvld_D : Dvld_E;
    assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_need_key ? S_KEY : S_DATA;
            S_KEY:  w_next = S_DATA;
            S_DATA: if (r_drdy) w_next = S_WAIT;
            S_WAIT: if (w_dvld || w_timeout) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_mode      <= MODE_ENC;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_key       <= '0;
            r_krdy      <= 1'b0;
            r_din       <= '0;
            r_drdy      <= 1'b0;
            r_en_e      <= 1'b0;
            r_en_d      <= 1'b0;
            r_kv_e      <= 1'b0;
            r_kv_d      <= 1'b0;
            r_kc_e      <= '0;
            r_kc_d      <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            // Strobes are decoded from the next state so each pulse lines up with its state.
            r_req_ready <= (w_next == S_IDLE);
            r_krdy      <= (w_next == S_KEY);
            r_drdy      <= (w_next == S_DATA) && !w_bsy;
            r_rsp_valid <= (w_next == S_RESP);

            if (w_accept) begin
                r_mode <= req_mode;
                r_en_e <= (req_mode == MODE_ENC);
                r_en_d <= (req_mode == MODE_DEC);
                r_din  <= req_data;
                if (w_need_key) r_key <= req_key;
            end

            if (r_state == S_KEY) begin
                if (r_mode == MODE_DEC) begin
                    r_kv_d <= 1'b1;
                    r_kc_d <= r_key;
                end else begin
                    r_kv_e <= 1'b1;
                    r_kc_e <= r_key;
                end
            end

            if (r_state == S_DATA && r_drdy) r_cnt <= '0;

            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_dvld) begin
                    r_rsp_data <= r_mode ? Dout_D : Dout_E;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    // A silent core may have lost its key, so force a reload next time.
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                    if (r_mode == MODE_DEC) r_kv_d <= 1'b0;
                    else                    r_kv_e <= 1'b0;
                end
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign Key       = r_key;
    assign Krdy      = r_krdy;
    assign Din       = r_din;
    assign Drdy      = r_drdy;
    assign EN_E      = r_en_e;
    assign EN_D      = r_en_d;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl with stub AES cores that answer FIPS-197
// vectors for the matching key and Din^Key for anything else.
module tb_aes_host_ctrl;
    import aes_pkg::*;

    localparam int TIMEOUT = 32;
    localparam int N_LAT   = 4;
    localparam blk_t K2    = 128'hffeeddccbbaa99887766554433221100;
    localparam blk_t D2    = 128'h0123456789abcdeffedcba9876543210;

    logic         CLK, RSTn;
    logic         req_valid, req_ready, req_mode, req_knew;
    logic [127:0] req_key, req_data;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [127:0] rsp_data, Key, Din, Dout_E, Dout_D;
    logic         Krdy, Drdy, EN_E, EN_D, BSY_E, BSY_D, Dvld_E, Dvld_D;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int krdy_tot = 0, drdy_tot = 0, both_tot = 0;
    int acc, lat, k0, d0;
    logic mute = 1'b0;
    logic busy_force = 1'b0;

    aes_host_ctrl #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_knew(req_knew), .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .Key(Key), .Krdy(Krdy), .Din(Din), .Drdy(Drdy),
        .EN_E(EN_E), .EN_D(EN_D), .BSY_E(BSY_E), .BSY_D(BSY_D),
        .Dvld_E(Dvld_E), .Dvld_D(Dvld_D), .Dout_E(Dout_E), .Dout_D(Dout_D),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    always @(posedge CLK) cyc <= cyc + 1;

    // Stub cores: Dvld goes high N_LAT cycles after the Drdy cycle.
    blk_t sk_e = '0, sk_d = '0, sd_e = '0, sd_d = '0;
    int cnt_e = 0, cnt_d = 0;
    initial begin
        Dvld_E = 1'b0; Dvld_D = 1'b0; Dout_E = '0; Dout_D = '0;
    end
    always @(posedge CLK) begin
        if (Krdy && EN_E) sk_e <= Key;
        if (Krdy && EN_D) sk_d <= Key;
        if (Drdy && EN_E && !mute) begin
            cnt_e <= N_LAT - 1; sd_e <= Din;
        end else if (cnt_e != 0) cnt_e <= cnt_e - 1;
        if (Drdy && EN_D && !mute) begin
            cnt_d <= N_LAT - 1; sd_d <= Din;
        end else if (cnt_d != 0) cnt_d <= cnt_d - 1;
        Dvld_E <= (cnt_e == 1);
        Dvld_D <= (cnt_d == 1);
        Dout_E <= (cnt_e == 1) ? ((sk_e == FIPS_KEY && sd_e == FIPS_PT) ? FIPS_CT : (sd_e ^ sk_e)) : '0;
        Dout_D <= (cnt_d == 1) ? ((sk_d == FIPS_DKEY && sd_d == FIPS_CT) ? FIPS_PT : (sd_d ^ sk_d)) : '0;
    end
    assign BSY_E = (cnt_e != 0) || busy_force;
    assign BSY_D = (cnt_d != 0);

    // Strobe monitor.
    always @(negedge CLK) begin
        if (Krdy) krdy_tot <= krdy_tot + 1;
        if (Drdy) drdy_tot <= drdy_tot + 1;
        if (Krdy && Drdy) both_tot <= both_tot + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic mode, input logic knew, input blk_t key, input blk_t data);
        @(negedge CLK);
        req_mode = mode; req_knew = knew; req_key = key; req_data = data;
        req_valid = 1'b1;
        k0 = krdy_tot; d0 = drdy_tot;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge CLK);
        chk("req_accept", req_ready, 1'b1);
        acc = cyc + 1;
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge CLK);
        chk("rsp_arrive", rsp_valid, 1'b1);
        lat = cyc - acc;
    endtask

    task automatic ack_rsp();
        @(negedge CLK);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
    endtask

    task automatic full_req(input string tag, input logic mode, input logic knew, input blk_t key,
                            input blk_t data, input blk_t exp_data, input int exp_lat, input int exp_krdy);
        start_req(mode, knew, key, data);
        wait_rsp();
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, rsp_err, 1'b0);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_krdy"}, krdy_tot - k0, exp_krdy);
        chk({tag, "_drdy"}, drdy_tot - d0, 1);
        chk({tag, "_en"}, {EN_E, EN_D}, mode ? 2'b01 : 2'b10);
    endtask

    initial begin
        RSTn = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_knew = 1'b0;
        req_key = '0; req_data = '0; rsp_ready = 1'b0;
        #2;
        chk("rst_outs", {req_ready, rsp_valid, rsp_err, Krdy, Drdy, EN_E, EN_D, dbg_state}, '0);
        chk("rst_blks", {rsp_data, Key, Din} == '0, 1'b1);
        @(negedge CLK); @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        chk("idle_ready", req_ready, 1'b1);

        // Encrypt with forced key load, decrypt on cache miss, encrypt cache hit.
        full_req("enc_new", MODE_ENC, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, N_LAT + 2, 1);
        ack_rsp();
        full_req("dec", MODE_DEC, 1'b0, FIPS_DKEY, FIPS_CT, FIPS_PT, N_LAT + 2, 1);
        ack_rsp();
        full_req("enc_hit", MODE_ENC, 1'b0, FIPS_KEY, FIPS_PT, FIPS_CT, N_LAT + 1, 0);
        ack_rsp();

        // Response backpressure.
        full_req("bp", MODE_ENC, 1'b0, FIPS_KEY, FIPS_PT, FIPS_CT, N_LAT + 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_hold", {rsp_valid, req_ready, rsp_err}, 3'b100);
            chk("bp_data", rsp_data, FIPS_CT);
        end
        ack_rsp();
        chk("bp_done", {rsp_valid, req_ready}, 2'b01);

        // Core busy holds off Drdy.
        busy_force = 1'b1;
        start_req(MODE_ENC, 1'b0, FIPS_KEY, FIPS_PT);
        for (int i = 0; i < 3; i++) begin
            chk("busy_hold", {Drdy, dbg_state}, {1'b0, S_DATA});
            @(negedge CLK);
        end
        busy_force = 1'b0;
        wait_rsp();
        chk("busy_data", rsp_data, FIPS_CT);
        chk("busy_lat", lat, N_LAT + 5);
        ack_rsp();

        // Changed key without knew still reloads.
        full_req("newkey", MODE_ENC, 1'b0, K2, D2, D2 ^ K2, N_LAT + 2, 1);
        ack_rsp();

        // Timeout, then the same key must be reloaded.
        mute = 1'b1;
        start_req(MODE_ENC, 1'b0, K2, D2);
        wait_rsp();
        chk("to_err", rsp_err, 1'b1);
        chk("to_data", rsp_data, '0);
        chk("to_lat", lat, TIMEOUT + 1);
        chk("to_krdy", krdy_tot - k0, 0);
        ack_rsp();
        mute = 1'b0;
        full_req("after_to", MODE_ENC, 1'b0, K2, D2, D2 ^ K2, N_LAT + 2, 1);
        ack_rsp();

        // Reset while waiting on the core.
        mute = 1'b1;
        start_req(MODE_ENC, 1'b0, FIPS_KEY, FIPS_PT);
        for (int i = 0; i < 20 && dbg_state !== S_WAIT; i++) @(negedge CLK);
        chk("rw_in_wait", dbg_state, S_WAIT);
        RSTn = 1'b0;
        #1;
        chk("rw_outs", {req_ready, rsp_valid, rsp_err, Krdy, Drdy, EN_E, EN_D, dbg_state}, '0);
        chk("rw_blks", {rsp_data, Key, Din} == '0, 1'b1);
        @(negedge CLK);
        RSTn = 1'b1;
        mute = 1'b0;
        full_req("after_rst", MODE_ENC, 1'b0, FIPS_KEY, FIPS_PT, FIPS_CT, N_LAT + 2, 1);
        ack_rsp();

        chk("krdy_drdy_overlap", both_tot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
